// File: rtl/psram_pkg.sv
// Shared PSRAM definitions: command opcodes, power-up FSM states and counter sizing.
package psram_pkg;

  localparam logic [7:0] CMD_RSTEN = 8'h66;
  localparam logic [7:0] CMD_RST   = 8'h99;
  localparam logic [7:0] CMD_NONE  = 8'h00;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_LOCK_STABLE,
    ST_PWRUP_WAIT,
    ST_CMD_RSTEN,
    ST_CMD_RST,
    ST_POST_RST,
    ST_READY
  } pwrup_state_t;

  // The shared counter holds at most (largest duration - 1), so clog2 of the largest is enough.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/cdc_sync2.sv
// Two-flop synchronizer for a single-bit level crossing into the clk domain.
module cdc_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/psram_powerup_seq.sv
// PSRAM power-up sequencer: waits for a stable PLL lock and the power-up delay, issues
// RESET-ENABLE / RESET, then releases downstream reset. Losing lock restarts the sequence.
module psram_powerup_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int PWRUP_CYCLES       = 12150,
  parameter int POST_RST_CYCLES    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_code,
  output logic       sys_rst_n,
  output logic       init_done,
  output logic [3:0] lock_lost_cnt
);

  import psram_pkg::*;

  localparam int CW = cnt_width(LOCK_STABLE_CYCLES, PWRUP_CYCLES, POST_RST_CYCLES);

  localparam logic [CW-1:0] LOCK_LOAD  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] PWRUP_LOAD = CW'(PWRUP_CYCLES - 1);
  localparam logic [CW-1:0] POST_LOAD  = CW'(POST_RST_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  pwrup_state_t  state;
  logic [CW-1:0] cnt;
  logic          lock_s;

  cdc_sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Timed states load cnt with (duration - 1) on entry and leave when it reaches zero.
  // Outputs are set on the same edge as the state change so they are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_WAIT_LOCK;
      cnt           <= '0;
      cmd_valid     <= 1'b0;
      cmd_code      <= CMD_NONE;
      sys_rst_n     <= 1'b0;
      init_done     <= 1'b0;
      lock_lost_cnt <= 4'd0;
    end else if (!lock_s && state != ST_WAIT_LOCK) begin
      state     <= ST_WAIT_LOCK;
      cnt       <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= CMD_NONE;
      sys_rst_n <= 1'b0;
      init_done <= 1'b0;
      if (state == ST_READY && lock_lost_cnt != 4'hF) begin
        lock_lost_cnt <= lock_lost_cnt + 4'd1;
      end
    end else begin
      case (state)
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state <= ST_LOCK_STABLE;
            cnt   <= LOCK_LOAD;
          end
        end
        ST_LOCK_STABLE: begin
          if (cnt == '0) begin
            state <= ST_PWRUP_WAIT;
            cnt   <= PWRUP_LOAD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_PWRUP_WAIT: begin
          if (cnt == '0) begin
            state     <= ST_CMD_RSTEN;
            cmd_valid <= 1'b1;
            cmd_code  <= CMD_RSTEN;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_CMD_RSTEN: begin
          if (cmd_valid && cmd_ready) begin
            state    <= ST_CMD_RST;
            cmd_code <= CMD_RST;
          end
        end
        ST_CMD_RST: begin
          if (cmd_valid && cmd_ready) begin
            state     <= ST_POST_RST;
            cmd_valid <= 1'b0;
            cmd_code  <= CMD_NONE;
            cnt       <= POST_LOAD;
          end
        end
        ST_POST_RST: begin
          if (cnt == '0) begin
            state     <= ST_READY;
            sys_rst_n <= 1'b1;
            init_done <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_READY: begin
          state <= ST_READY;
        end
        default: begin
          state <= ST_WAIT_LOCK;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psram_powerup_seq.sv
// Scoreboard bench for psram_powerup_seq: a timeline model predicts every cycle's outputs,
// a monitor process compares them against the DUT after each clock edge.
module tb_psram_powerup_seq;

  localparam int L = 4;
  localparam int P = 10;
  localparam int Q = 3;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       pll_lock  = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic       sys_rst_n;
  logic       init_done;
  logic [3:0] lock_lost_cnt;

  psram_powerup_seq #(
    .LOCK_STABLE_CYCLES (L),
    .PWRUP_CYCLES       (P),
    .POST_RST_CYCLES    (Q)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_lock      (pll_lock),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_code      (cmd_code),
    .sys_rst_n     (sys_rst_n),
    .init_done     (init_done),
    .lock_lost_cnt (lock_lost_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] v;
    string       tag;
  } exp_t;

  exp_t  sb_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "reset";

  // Timeline model: age counts edges since the sequence started (lock first seen),
  // commands begin at age L+P, ready comes Q edges after the second accepted command.
  bit         m_h1, m_h2, m_active, m_valid, m_ready;
  int         m_age, m_acks, m_a2, m_lost;
  logic [7:0] m_code;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelStep(input bit r, input bit pl, input bit cr);
    bit ls;
    if (!r) begin
      m_h1 = 0; m_h2 = 0; m_active = 0;
      m_age = 0; m_acks = 0; m_a2 = 0; m_lost = 0;
    end else begin
      ls   = m_h2;
      m_h2 = m_h1;
      m_h1 = pl;
      if (m_active && !ls) begin
        if (m_ready && m_lost < 15) m_lost++;
        m_active = 0;
        m_acks   = 0;
      end else if (!m_active && ls) begin
        m_active = 1;
        m_age    = 0;
        m_acks   = 0;
      end else if (m_active) begin
        m_age++;
        if (m_valid && cr) begin
          m_acks++;
          if (m_acks == 2) m_a2 = m_age;
        end
      end
    end
    m_valid = m_active && (m_age >= L + P) && (m_acks < 2);
    m_code  = !m_valid ? 8'h00 : ((m_acks == 0) ? 8'h66 : 8'h99);
    m_ready = m_active && (m_acks == 2) && (m_age >= m_a2 + Q);
  endtask

  task automatic applyStimulus(input bit r, input bit pl, input bit cr);
    exp_t e;
    @(negedge clk);
    rst_n     = r;
    pll_lock  = pl;
    cmd_ready = cr;
    modelStep(r, pl, cr);
    e.v   = {m_valid, m_code, m_ready, m_ready, 4'(m_lost)};
    e.tag = phase;
    sb_q.push_back(e);
  endtask

  task automatic runUntilReady(input int budget);
    for (int n = 0; n < budget && !m_ready; n++) applyStimulus(1, 1, 1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput({e.tag, "/outputs"},
                    32'({cmd_valid, cmd_code, sys_rst_n, init_done, lock_lost_cnt}), 32'(e.v));
      end
    end
  end

  initial begin
    bit r, pl, cr;
    int drop;

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0);

    // Nominal power-up with fixed edge numbers counted from the first edge out of reset.
    phase = "nominal";
    for (int ed = 0; ed < 24; ed++) begin
      applyStimulus(1, 1, 1);
      @(posedge clk);
      #2;
      case (ed)
        15: checkOutput("nom_idle_e15",  32'(cmd_valid), 32'd0);
        16: checkOutput("nom_rsten_e16", 32'({cmd_valid, cmd_code}), 32'h166);
        17: checkOutput("nom_rst_e17",   32'({cmd_valid, cmd_code}), 32'h199);
        18: checkOutput("nom_drop_e18",  32'({cmd_valid, cmd_code}), 32'h000);
        20: checkOutput("nom_notrdy_e20", 32'({sys_rst_n, init_done}), 32'd0);
        21: checkOutput("nom_ready_e21", 32'({sys_rst_n, init_done}), 32'd3);
        default: ;
      endcase
    end

    phase = "stall";
    applyStimulus(0, 1, 0);
    for (int n = 0; n < 60 && !m_valid; n++) applyStimulus(1, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0);
    runUntilReady(40);

    phase = "glitch";
    applyStimulus(0, 0, 1);
    for (int n = 0; n < 10 && !m_active; n++) applyStimulus(1, 1, 1);
    applyStimulus(1, 0, 1);
    runUntilReady(80);

    phase = "abort";
    applyStimulus(0, 1, 0);
    for (int n = 0; n < 60 && !m_valid; n++) applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0);
    runUntilReady(60);

    phase = "reset_mid";
    applyStimulus(0, 1, 1);
    for (int n = 0; n < 60 && !(m_active && m_age == L + 3); n++) applyStimulus(1, 1, 1);
    applyStimulus(0, 1, 1);
    runUntilReady(60);

    phase = "lock_loss";
    applyStimulus(0, 1, 1);
    runUntilReady(60);
    for (int k = 0; k < 20; k++) begin
      for (int c = 0; c < 3; c++) applyStimulus(1, 0, 1);
      @(posedge clk);
      #2;
      checkOutput("loss_release", 32'({sys_rst_n, init_done}), 32'd0);
      if (k == 2) checkOutput("loss_cnt_3", 32'(lock_lost_cnt), 32'd3);
      runUntilReady(60);
    end
    checkOutput("loss_cnt_sat", 32'(lock_lost_cnt), 32'd15);

    phase = "random";
    drop  = 0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 599) != 0);
      if (drop == 0 && $urandom_range(0, 79) == 0) drop = $urandom_range(1, 6);
      pl = (drop == 0);
      if (drop > 0) drop--;
      cr = 1'($urandom_range(0, 1));
      applyStimulus(r, pl, cr);
    end

    phase = "drain";
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1);
    @(posedge clk);
    #3;
    checkOutput("scoreboard_drain", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
